// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) round-robin arbiter in front of a single memory with
// fixed read latency MEM_LAT; one read in flight at a time, writes complete in one cycle.
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_raddr,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t        state, state_next;
    logic          last_d;      // 1 = data port was granted most recently
    logic          owner_d;     // port that owns the read in flight
    logic [2:0]    cnt;
    logic [AW-1:0] raddr_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] wdata_q;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        f_gnt      = 1'b0;
        d_gnt      = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_raddr  = raddr_q;
        mem_waddr  = waddr_q;
        mem_wdata  = wdata_q;
        case (state)
            IDLE: begin
                // Grants are combinational, so they must also be masked while reset is held.
                if (rst_n) begin
                    if (f_req && (!d_req || last_d)) begin
                        f_gnt      = 1'b1;
                        mem_re     = 1'b1;
                        mem_raddr  = f_addr;
                        state_next = RD_WAIT;
                    end else if (d_req) begin
                        d_gnt = 1'b1;
                        if (d_we) begin
                            mem_we    = 1'b1;
                            mem_waddr = d_addr;
                            mem_wdata = d_wdata;
                        end else begin
                            mem_re     = 1'b1;
                            mem_raddr  = d_addr;
                            state_next = RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (cnt == 3'd0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_d   <= 1'b1;
            owner_d  <= 1'b0;
            cnt      <= 3'd0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            f_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            state    <= state_next;
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (f_gnt || d_gnt) last_d <= d_gnt;
            if (mem_re) begin
                raddr_q <= mem_raddr;
                owner_d <= d_gnt;
                cnt     <= 3'(MEM_LAT - 1);
            end
            if (mem_we) begin
                waddr_q <= mem_waddr;
                wdata_q <= mem_wdata;
            end
            if (state == RD_WAIT) begin
                if (cnt == 3'd0) begin
                    if (owner_d) begin
                        d_rdata  <= mem_rdata;
                        d_rvalid <= 1'b1;
                    end else begin
                        f_rdata  <= mem_rdata;
                        f_rvalid <= 1'b1;
                    end
                end else begin
                    cnt <= cnt - 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a cycle-scheduled transaction model predicts
// every output each cycle; includes reset bursts that abort reads in flight.
module tb_mem_arbiter;

    localparam int AW      = 16;
    localparam int DW      = 16;
    localparam int MEM_LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          f_req, d_req, d_we;
    logic [AW-1:0] f_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          f_gnt, f_rvalid, d_gnt, d_rvalid, mem_re, mem_we;
    logic [DW-1:0] f_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_raddr, mem_waddr;

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Memory contents seen by reads; indexed by the low address byte.
    logic [DW-1:0] mem [256];

    // Reference model: a read granted in cycle T completes (rvalid) in cycle T+MEM_LAT+1,
    // and the port is busy until then.
    int            free_at, done_at;
    bit            done_d, last_d;
    logic [AW-1:0] done_addr, raddr_m, waddr_m;
    logic [DW-1:0] wdata_m, frd_m, drd_m;
    bit            fw, dw;

    bit f_pend, d_pend;
    int rst_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all(input bit e_fg, input bit e_dg, input bit e_frv, input bit e_drv,
                             input bit e_re, input bit e_we,
                             input logic [AW-1:0] e_ra, input logic [AW-1:0] e_wa,
                             input logic [DW-1:0] e_wd, input logic [DW-1:0] e_frd,
                             input logic [DW-1:0] e_drd);
        check("f_gnt",     32'(f_gnt),     32'(e_fg));
        check("d_gnt",     32'(d_gnt),     32'(e_dg));
        check("f_rvalid",  32'(f_rvalid),  32'(e_frv));
        check("d_rvalid",  32'(d_rvalid),  32'(e_drv));
        check("mem_re",    32'(mem_re),    32'(e_re));
        check("mem_we",    32'(mem_we),    32'(e_we));
        check("mem_raddr", 32'(mem_raddr), 32'(e_ra));
        check("mem_waddr", 32'(mem_waddr), 32'(e_wa));
        check("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        check("f_rdata",   32'(f_rdata),   32'(e_frd));
        check("d_rdata",   32'(d_rdata),   32'(e_drd));
    endtask

    task automatic model_reset();
        free_at = 0;
        done_at = -1;
        done_d  = 1'b0;
        last_d  = 1'b1;
        raddr_m = '0;
        waddr_m = '0;
        wdata_m = '0;
        frd_m   = '0;
        drd_m   = '0;
        fw      = 1'b0;
        dw      = 1'b0;
    endtask

    task automatic model_step();
        bit idle, frv, drv, e_re, e_we;
        idle = (cyc >= free_at);
        frv  = (cyc == done_at) && !done_d;
        drv  = (cyc == done_at) && done_d;
        if (frv) frd_m = mem[done_addr[7:0]];
        if (drv) drd_m = mem[done_addr[7:0]];
        fw   = idle && f_req && (!d_req || last_d);
        dw   = idle && d_req && !fw;
        e_re = fw || (dw && !d_we);
        e_we = dw && d_we;
        if (e_re) raddr_m = fw ? f_addr : d_addr;
        if (e_we) begin
            waddr_m = d_addr;
            wdata_m = d_wdata;
        end
        check_all(fw, dw, frv, drv, e_re, e_we, raddr_m, waddr_m, wdata_m, frd_m, drd_m);
        if (e_re) begin
            done_at   = cyc + MEM_LAT + 1;
            free_at   = done_at;
            done_d    = dw;
            done_addr = raddr_m;
        end
        if (fw || dw) last_d = dw;
    endtask

    task automatic drive_stim(input bit burst);
        if (burst) f_pend = 1'b0;
        if (f_pend && $urandom_range(0, 29) == 0) f_pend = 1'b0;
        if (d_pend && !burst && $urandom_range(0, 29) == 0) d_pend = 1'b0;
        if (!f_pend && !burst && $urandom_range(0, 3) == 0) begin
            f_pend = 1'b1;
            f_addr = AW'($urandom);
        end
        if (!d_pend && (burst || $urandom_range(0, 3) == 0)) begin
            d_pend  = 1'b1;
            d_we    = burst ? 1'b1 : 1'($urandom_range(0, 1));
            d_addr  = AW'($urandom);
            d_wdata = DW'($urandom);
        end
        f_req = f_pend;
        d_req = d_pend;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = DW'($urandom);
        rst_n = 1'b0;
        {f_req, d_req, d_we} = '0;
        f_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        f_pend = 1'b0; d_pend = 1'b0;
        rst_cnt = 2;
        model_reset();

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (rst_cnt > 0) begin
                // Requests stay high through reset: grants must stay masked, and on release
                // both ports tie, which fetch must win.
                rst_n   = 1'b0;
                rst_cnt--;
                f_pend  = 1'b1;
                d_pend  = 1'b1;
                d_we    = 1'b0;
                f_addr  = AW'($urandom);
                d_addr  = AW'($urandom);
                d_wdata = DW'($urandom);
                f_req   = 1'b1;
                d_req   = 1'b1;
            end else begin
                rst_n = 1'b1;
                drive_stim((i % 600) >= 450);
            end
            mem_rdata = (cyc == done_at - 1) ? mem[done_addr[7:0]] : DW'($urandom);

            @(negedge clk);
            if (!rst_n) begin
                check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
                model_reset();
            end else begin
                model_step();
                if (fw) f_pend = 1'b0;
                if (dw) d_pend = 1'b0;
                // Abort a fresh fetch read by resetting in the following cycle.
                if (fw && $urandom_range(0, 19) == 0) rst_cnt = 2;
            end
            cyc++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 16, address width; DW, default 16, data width; MEM_LAT, default 2, memory read latency in cycles, legal range 1..7.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 f_req  input  1  fetch read request; held until f_gnt.
REQ-005 f_addr  input  AW  fetch address; held stable with f_req.
REQ-006 f_gnt  output  1  one-cycle pulse; fetch request accepted.
REQ-007 f_rvalid  output  1  one-cycle pulse; f_rdata is valid.
REQ-008 f_rdata  output  DW  fetch read data.
REQ-009 d_req  input  1  data-port request; held until d_gnt.
REQ-010 d_we  input  1  1 = write, 0 = read; qualified by d_req.
REQ-011 d_addr  input  AW  data-port address.
REQ-012 d_wdata  input  DW  write data.
REQ-013 d_gnt  output  1  one-cycle pulse; data request accepted.
REQ-014 d_rvalid  output  1  one-cycle pulse; d_rdata is valid (reads only).
REQ-015 d_rdata  output  DW  data-port read data.
REQ-016 mem_raddr  output  AW  memory read address.
REQ-017 mem_waddr  output  AW  memory write address.
REQ-018 mem_wdata  output  DW  memory write data.
REQ-019 mem_re  output  1  memory read strobe.
REQ-020 mem_we  output  1  memory write strobe.
REQ-021 mem_rdata  input  DW  memory read data; valid MEM_LAT cycles after the mem_re cycle.

Function
REQ-022 The FSM SHALL have the states IDLE and RD_WAIT.
REQ-023 In IDLE with at least one request, the arbiter SHALL, in the same cycle, pick one winner, pulse its gnt, drive mem_re or mem_we, and drive the winner's address.
REQ-024 Arbitration SHALL be round-robin: with both requests active, the port not granted last wins; with one request active, that port wins.
REQ-025 The last-granted pointer SHALL update on every grant.
REQ-026 A granted write SHALL drive mem_waddr = d_addr, mem_wdata = d_wdata and mem_we = 1 for one cycle, with the FSM remaining in IDLE and no rvalid.
REQ-027 A granted read in cycle T SHALL assert mem_re = 1 in cycle T only, register the address onto mem_raddr, and enter RD_WAIT.
REQ-028 In RD_WAIT, mem_raddr SHALL be held stable and the arbiter SHALL issue no gnt, mem_re or mem_we.
REQ-029 A down-counter SHALL sample mem_rdata in cycle T+MEM_LAT into the owning port's rdata register.
REQ-030 In cycle T+MEM_LAT+1, the owning port's rvalid SHALL be 1, the FSM SHALL be back in IDLE, and a new grant SHALL be permitted in that same cycle.
REQ-031 The rdata registers SHALL hold their value until the next read completes for that port.
REQ-032 f_rvalid and d_rvalid SHALL never be asserted together.
REQ-033 f_gnt and d_gnt SHALL never be asserted together.
REQ-034 A request dropped before its grant SHALL be ignored, with no side effect.
REQ-035 When no access is in progress, mem_raddr and mem_waddr SHALL hold their last values.
REQ-036 Back-to-back writes SHALL be granted on consecutive cycles.

Reset
REQ-037 While rst_n = 0, all gnt, rvalid, mem_re and mem_we outputs SHALL be 0.
REQ-038 While rst_n = 0, the addresses, wdata and rdata outputs SHALL be 0.
REQ-039 While rst_n = 0, the FSM SHALL be in IDLE.
REQ-040 While rst_n = 0, the last-granted pointer SHALL be 'data', so fetch wins the first tie.
REQ-041 A reset during RD_WAIT SHALL abort the read; no rvalid SHALL follow, and the aborted request is not retried.

Verification
REQ-042 Fetch read alone, MEM_LAT = 2, f_addr = 0x0010, mem_rdata = 0xBEEF at T+2 -> f_gnt at T, mem_re at T, f_rvalid at T+3 with f_rdata = 0xBEEF.
REQ-043 f_req and d_req (read) both raised in the first cycle after reset -> f_gnt first, d_gnt at T+3, d_rvalid at T+6.
REQ-044 d_req write 0x1234 to 0x0020 held together with a held f_req -> grants strictly alternate data/fetch/data; mem_we is 1 only in data-write grant cycles with mem_waddr = 0x0020 and mem_wdata = 0x1234.
REQ-045 Three consecutive data writes with no fetch -> d_gnt and mem_we high in 3 consecutive cycles, no rvalid.
REQ-046 rst_n pulsed low at T+1 of a fetch read -> f_rvalid never asserted, FSM in IDLE, mem_raddr = 0.
REQ-047 f_req raised during RD_WAIT of a data read -> f_gnt not before the d_rvalid cycle, f_gnt exactly in the d_rvalid cycle.
